// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, default timeout
// and a helper that classifies the states in which a load is in flight.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYC = 1024;

    function automatic logic is_busy(input state_e s);
        return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/program_loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the LIMIT-th consecutive idle cycle completes.
module loader_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Not gated by clr so the caller may derive clr from the next state.
    assign expired = en && (cnt_q == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a length-prefixed, checksummed program over a byte stream, writes
// the payload into program memory and holds the CPU in reset meanwhile.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output state_e            dbg_state
);

    localparam int CW = (ADDR_W > 8) ? ADDR_W : 8;

    state_e            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        acc_q, acc_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic              last_byte;
    logic              tmo_clr, tmo_en, tmo_expired;
    logic [CW-1:0]     idx_next;

    // Handshake: a byte moves on a rising edge where byte_valid and byte_ready
    // are both high; a simultaneous load_req wins and the byte is dropped.
    assign xfer      = byte_valid && byte_ready_q && !load_req;
    assign idx_next  = CW'(addr_q) + CW'(1);
    assign last_byte = (idx_next == CW'(len_q));

    assign tmo_clr = load_req || xfer || !is_busy(state_q);
    assign tmo_en  = is_busy(state_q) && !xfer;

    loader_timeout #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_req) begin
            state_d = ST_LEN;
        end else begin
            case (state_q)
                ST_LEN: begin
                    if (xfer)             state_d = (byte_data == 8'd0) ? ST_ERR : ST_DATA;
                    else if (tmo_expired) state_d = ST_ERR;
                end
                ST_DATA: begin
                    if (xfer && last_byte) state_d = ST_CSUM;
                    else if (tmo_expired)  state_d = ST_ERR;
                end
                ST_CSUM: begin
                    if (xfer)             state_d = (byte_data == acc_q) ? ST_DONE : ST_ERR;
                    else if (tmo_expired) state_d = ST_ERR;
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so they track the
    // state register with no extra cycle of lag.
    always_comb begin
        byte_ready_d = is_busy(state_d);
        busy_d       = is_busy(state_d);
        cpu_rst_d    = is_busy(state_d) || (state_d == ST_ERR);
        done_d       = (state_d == ST_DONE);
        error_d      = (state_d == ST_ERR);
    end

    always_comb begin
        len_d       = len_q;
        addr_d      = addr_q;
        acc_d       = acc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (load_req) begin
            len_d  = 8'd0;
            addr_d = '0;
            acc_d  = 8'd0;
        end else if (xfer) begin
            if (state_q == ST_LEN) begin
                len_d = byte_data;
            end else if (state_q == ST_DATA) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = byte_data;
                addr_d      = addr_q + ADDR_W'(1);
                acc_d       = acc_q + byte_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= 8'd0;
            addr_q       <= '0;
            acc_q        <= 8'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 8'd0;
            cpu_rst_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            len_q        <= len_d;
            addr_q       <= addr_d;
            acc_q        <= acc_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scenario tasks drive byte streams, expected memory
// writes are queued as payload bytes are sent and checked as mem_we fires.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int TMO    = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;
    state_e            dbg_state;

    int total = 0;
    int bad   = 0;
    logic [ADDR_W+7:0] exp_q[$];
    logic [ADDR_W+7:0] mon_exp;

    program_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .dbg_state  (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // scoreboard: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mem_write unexpected: got addr=%0h data=%0h, none expected", mem_addr, mem_wdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== mon_exp) begin
                    bad++;
                    $display("FAIL mem_write: got addr=%0h data=%0h, want addr=%0h data=%0h",
                             mem_addr, mem_wdata, mon_exp[15:8], mon_exp[7:0]);
                end
            end
        end
    end

    // driver tasks (all drive at 1 time unit after a rising edge)
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
    endtask

    task automatic idle(input int n);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        tick(n);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        byte_valid = 1'b1;
        byte_data  = b;
        w = 0;
        while (byte_ready !== 1'b1 && w < 20) begin
            tick(1);
            w++;
        end
        total++;
        if (w >= 20) begin
            bad++;
            $display("FAIL send_byte: byte_ready=%b after %0d cycles, want 1", byte_ready, w);
        end else begin
            tick(1);
        end
    endtask

    task automatic push_wr(input int addr, input logic [7:0] data);
        exp_q.push_back({addr[ADDR_W-1:0], data});
    endtask

    task automatic test_reset();
        rst = 1'b0; load_req = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        #1 rst = 1'b1;
        #1;
        total++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst} !== '0 || dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_values: got rdy=%b we=%b addr=%0h wd=%0h busy=%b done=%b err=%b cpu=%b st=%0d, want all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst, dbg_state);
        end
        @(posedge clk); #1 rst = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h05;
        tick(4);
        total++;
        if ({byte_ready, busy, cpu_rst} !== 3'b000) begin
            bad++;
            $display("FAIL no_load_after_reset: got rdy/busy/cpu=%b, want 000", {byte_ready, busy, cpu_rst});
        end
        idle(2);
    endtask

    task automatic test_good_load();
        pulse_load();
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b10011) begin
            bad++;
            $display("FAIL good_start: got status=%b, want 10011", {busy, done, error, cpu_rst, byte_ready});
        end
        send_byte(8'h03);
        push_wr(0, 8'h11); send_byte(8'h11);
        push_wr(1, 8'h22); send_byte(8'h22);
        push_wr(2, 8'h33); send_byte(8'h33);
        total++;
        if ({busy, cpu_rst} !== 2'b11) begin
            bad++;
            $display("FAIL good_before_csum: got busy/cpu=%b, want 11", {busy, cpu_rst});
        end
        send_byte(8'h66);
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b01000) begin
            bad++;
            $display("FAIL good_done: got status=%b, want 01000", {busy, done, error, cpu_rst, byte_ready});
        end
        idle(3);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL good_writes: got %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        pulse_load();
        total++;
        if ({done, error, busy} !== 3'b001) begin
            bad++;
            $display("FAIL bad_csum_clear: got done/err/busy=%b, want 001", {done, error, busy});
        end
        send_byte(8'h02);
        push_wr(0, 8'hAA); send_byte(8'hAA);
        push_wr(1, 8'hBB); send_byte(8'hBB);
        send_byte(8'h00);
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b00110) begin
            bad++;
            $display("FAIL bad_csum_err: got status=%b, want 00110", {busy, done, error, cpu_rst, byte_ready});
        end
        idle(3);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL bad_csum_writes: got %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_zero_len();
        pulse_load();
        send_byte(8'h00);
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b00110) begin
            bad++;
            $display("FAIL zero_len: got status=%b, want 00110", {busy, done, error, cpu_rst, byte_ready});
        end
        idle(3);
    endtask

    task automatic test_timeout();
        pulse_load();
        send_byte(8'h01);
        idle(TMO - 1);
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b10011) begin
            bad++;
            $display("FAIL timeout_early: got status=%b, want 10011", {busy, done, error, cpu_rst, byte_ready});
        end
        tick(1);
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b00110) begin
            bad++;
            $display("FAIL timeout_expire: got status=%b, want 00110", {busy, done, error, cpu_rst, byte_ready});
        end
        idle(3);
    endtask

    task automatic test_restart();
        pulse_load();
        send_byte(8'h04);
        push_wr(0, 8'h01); send_byte(8'h01);
        push_wr(1, 8'h02); send_byte(8'h02);
        // restart while a byte is offered: that byte must be dropped
        byte_valid = 1'b1; byte_data = 8'h77;
        pulse_load();
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b10011) begin
            bad++;
            $display("FAIL restart_state: got status=%b, want 10011", {busy, done, error, cpu_rst, byte_ready});
        end
        send_byte(8'h01);
        push_wr(0, 8'h05); send_byte(8'h05);
        send_byte(8'h05);
        total++;
        if ({busy, done, error, cpu_rst, byte_ready} !== 5'b01000) begin
            bad++;
            $display("FAIL restart_done: got status=%b, want 01000", {busy, done, error, cpu_rst, byte_ready});
        end
        idle(3);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL restart_writes: got %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_rst_mid();
        pulse_load();
        send_byte(8'h04);
        push_wr(0, 8'hA1); send_byte(8'hA1);
        send_byte(8'hA2);
        rst = 1'b1;
        #1;
        total++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst} !== '0 || dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL rst_mid_values: got rdy=%b we=%b addr=%0h wd=%0h busy=%b done=%b err=%b cpu=%b, want all 0",
                     byte_ready, mem_we, mem_addr, mem_wdata, busy, done, error, cpu_rst);
        end
        byte_valid = 1'b0;
        tick(2);
        rst = 1'b0;
        byte_valid = 1'b1; byte_data = 8'h33;
        tick(3);
        total++;
        if ({byte_ready, busy} !== 2'b00) begin
            bad++;
            $display("FAIL rst_mid_idle: got rdy/busy=%b, want 00", {byte_ready, busy});
        end
        idle(3);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL rst_mid_writes: got %0d writes missing, want 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        int n;
        logic [7:0] b, sum, c;
        logic good;
        for (int it = 0; it < 5; it++) begin
            n    = (it == 0) ? 255 : $urandom_range(1, 20);
            good = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            sum  = 8'h00;
            pulse_load();
            send_byte(8'(n));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                push_wr(i, b);
                send_byte(b);
                sum = sum + b;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
            end
            c = good ? sum : (sum ^ 8'h5A);
            send_byte(c);
            total++;
            if ({busy, done, error, cpu_rst} !== (good ? 4'b0100 : 4'b0011)) begin
                bad++;
                $display("FAIL random_load%0d n=%0d good=%b: got status=%b, want %b",
                         it, n, good, {busy, done, error, cpu_rst}, good ? 4'b0100 : 4'b0011);
            end
            idle(3);
            total++;
            if (exp_q.size() !== 0) begin
                bad++;
                $display("FAIL random_writes%0d: got %0d writes missing, want 0", it, exp_q.size());
            end
        end
    endtask

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        test_reset();
        test_good_load();
        test_bad_csum();
        test_zero_len();
        test_timeout();
        test_restart();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, program memory address width.
REQ-002 Parameter TIMEOUT_CYC, default 1024, max idle cycles between bytes during a load.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load_req  input  1  one-cycle pulse requesting a new program load.
REQ-006 byte_valid  input  1  loader-side byte present.
REQ-007 byte_data  input  8  loader-side byte.
REQ-008 byte_ready  output  1  block accepts byte; transfer occurs when byte_valid and byte_ready are both high at a rising edge.
REQ-009 mem_we  output  1  program memory write strobe, one cycle per payload byte.
REQ-010 mem_addr  output  ADDR_W  program memory write address.
REQ-011 mem_wdata  output  8  program memory write data.
REQ-012 cpu_rst  output  1  holds CPU in reset while high.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  last load succeeded; sticky until the next load_req.
REQ-015 error  output  1  last load failed; sticky until the next load_req.

Function
REQ-016 FSM states SHALL be IDLE, LEN, DATA, CSUM, DONE, ERR.
REQ-017 IDLE: load_req -> LEN; clear done/error, checksum accumulator, address counter and timeout counter.
REQ-018 load_req in any state other than IDLE SHALL restart the load (-> LEN, same clears); an in-flight byte transfer in that cycle is discarded.
REQ-019 byte_ready SHALL be high only in LEN, DATA and CSUM.
REQ-020 LEN: accepted byte = payload length N; N=0 -> ERR; else store N and -> DATA.
REQ-021 DATA: each accepted byte SHALL assert mem_we in the next cycle, with mem_addr = byte index (0..N-1) and mem_wdata = that byte; accumulator += byte mod 256.
REQ-022 DATA: after the N-th accepted byte -> CSUM; the address counter SHALL NOT wrap within one load (N <= 2^ADDR_W - 1).
REQ-023 CSUM: accepted byte equal to accumulator (8-bit) -> DONE, otherwise -> ERR.
REQ-024 Timeout: counter resets on every accepted byte and on state entry; reaching TIMEOUT_CYC consecutive idle cycles in LEN/DATA/CSUM -> ERR.
REQ-025 DONE: done=1, cpu_rst=0, busy=0; load_req -> LEN.
REQ-026 ERR: error=1, cpu_rst=1, busy=0; load_req -> LEN.
REQ-027 cpu_rst SHALL be 1 in LEN, DATA, CSUM and ERR; 0 in IDLE and DONE.
REQ-028 busy SHALL be 1 exactly in LEN, DATA, CSUM.
REQ-029 All outputs SHALL be registered; mem_we is 0 whenever no payload write is pending.

Reset
REQ-030 rst high SHALL immediately force IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, cpu_rst=0.
REQ-031 rst asserted mid-load SHALL abort with no further mem_we; memory content already written is not restored.
REQ-032 After rst release, no transfer SHALL be accepted until load_req.

Structure
REQ-033 FSM state encoding and the default TIMEOUT_CYC constant SHALL live in a shared package.
REQ-034 Optional sub-module loader_timeout (counter with clear/enable, expiry flag); everything else is a single module.
REQ-035 The block SHALL sit beside the CPU/program memory pair in the top level, driving the CPU reset and the memory write port.

Verification
REQ-036 load_req; bytes 03,11,22,33,66 -> writes (0,11),(1,22),(2,33); done=1; cpu_rst falls after the checksum byte.
REQ-037 load_req; bytes 02,AA,BB,00 -> two writes; error=1; cpu_rst stays 1.
REQ-038 load_req; byte 00 -> error=1, no mem_we.
REQ-039 load_req; 01, then idle TIMEOUT_CYC cycles -> error=1, no write at address 0 beyond none issued.
REQ-040 load_req; 04,01,02 then load_req; 01,05,05 -> restart at address 0, write (0,05), done=1.
REQ-041 rst asserted after the 2nd payload byte of N=4 -> all outputs at reset values that cycle; no later mem_we.
